// File: rtl/laser_vga_arbiter.sv
// rtl/laser_vga_arbiter.sv - round-robin arbiter sharing one VGA plot port among N laser datapaths
// Grants one tower per bounded burst, registers its pixels onto the plot port, then rotates priority.
module laser_vga_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BURST = 21
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      req,
  input  logic [N-1:0]      last,
  input  logic [15*N-1:0]   coords_in,
  input  logic [9*N-1:0]    colour_in,
  output logic [N-1:0]      gnt,
  output logic [N-1:0]      ack,
  output logic [7:0]        vga_x,
  output logic [6:0]        vga_y,
  output logic [8:0]        vga_colour,
  output logic              vga_plot,
  output logic              busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [7:0]    vga_x_q, vga_x_d;
  logic [6:0]    vga_y_q, vga_y_d;
  logic [8:0]    vga_colour_q, vga_colour_d;
  logic          vga_plot_q, vga_plot_d;

  logic [IW-1:0] pick_idx, cand, owner_inc;
  logic          pick_valid;
  int            j;
  logic [14:0]   sel_coords;
  logic [8:0]    sel_colour;
  logic          sel_req, sel_last;
  logic [4:0]    cnt_inc;

  // Scan from the highest offset down so the candidate nearest ptr is written last and wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    j          = 0;
    cand       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr_q) + i;
      if (j >= N) j = j - N;
      cand = IW'(j);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_coords = '0;
    sel_colour = '0;
    sel_req    = 1'b0;
    sel_last   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (owner_q == IW'(i)) begin
        sel_coords = coords_in[15*i +: 15];
        sel_colour = colour_in[9*i +: 9];
        sel_req    = req[i];
        sel_last   = last[i];
      end
    end
  end

  assign owner_inc = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
  assign cnt_inc   = cnt_q + 5'd1;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    gnt          = '0;
    ack          = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        gnt[owner_q] = 1'b1;
        ack[owner_q] = sel_req;
        if (sel_req) begin
          vga_plot_d   = 1'b1;
          vga_x_d      = sel_coords[14:7];
          vga_y_d      = sel_coords[6:0];
          vga_colour_d = sel_colour;
          cnt_d        = cnt_inc;
          if (sel_last || (cnt_inc == 5'(MAX_BURST))) begin
            ptr_d   = owner_inc;
            state_d = S_IDLE;
          end
        end else begin
          // Requester went away: end the burst without accepting a pixel; last is ignored.
          ptr_d   = owner_inc;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  assign busy       = (state_q == S_BURST);
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_laser_vga_arbiter.sv
// tb/tb_laser_vga_arbiter.sv - directed bench for laser_vga_arbiter
// Each tower is a simple pixel source that advances on ack; expected values are hand-derived per scenario.
module tb_laser_vga_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, last;
  logic [59:0] coords_in;
  logic [35:0] colour_in;
  logic [3:0]  gnt, ack;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [8:0]  vga_colour;
  logic        vga_plot, busy;

  int n_vec = 0;
  int n_bad = 0;

  int         rem [4];
  int         pix [4];
  int         seg [4];
  int         xbase [4];
  logic [8:0] col [4];

  logic [3:0] gnt_log  [0:63];
  logic [3:0] ack_log  [0:63];
  logic       plot_log [0:63];
  logic       busy_log [0:63];
  logic [7:0] x_log    [0:63];
  logic [6:0] y_log    [0:63];
  logic [8:0] c_log    [0:63];

  laser_vga_arbiter #(.N(4), .MAX_BURST(21)) dut (
    .clk(clk), .reset(reset), .req(req), .last(last),
    .coords_in(coords_in), .colour_in(colour_in),
    .gnt(gnt), .ack(ack), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req[i]  = (rem[i] > 0);
      last[i] = (((pix[i] + 1) % seg[i]) == 0);
      coords_in[15*i +: 15] = {8'(xbase[i] + pix[i]), 7'd30};
      colour_in[9*i +: 9]   = col[i];
    end
  endtask

  // Cycle c: inputs applied just after a rising edge, outputs sampled on the falling edge.
  task automatic run(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      drive();
      @(negedge clk);
      gnt_log[c]  = gnt;
      ack_log[c]  = ack;
      plot_log[c] = vga_plot;
      busy_log[c] = busy;
      x_log[c]    = vga_x;
      y_log[c]    = vga_y;
      c_log[c]    = vga_colour;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
        if (ack_log[c][i]) begin
          pix[i] = pix[i] + 1;
          rem[i] = rem[i] - 1;
        end
    end
  endtask

  task automatic clear_towers();
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0; pix[i] = 0; seg[i] = 100; xbase[i] = 16 * i; col[i] = 9'(i + 1);
    end
  endtask

  task automatic do_reset();
    clear_towers();
    reset = 1'b1;
    run(3);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_towers();
    for (int i = 0; i < 4; i++) begin
      rem[i] = 1; seg[i] = 1; xbase[i] = 200; col[i] = 9'h1ff;
    end
    reset = 1'b1;
    run(3);
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if (gnt_log[c] !== 4'b0000 || ack_log[c] !== 4'b0000 || plot_log[c] !== 1'b0 || busy_log[c] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_ctrl c=%0d gnt=%b ack=%b plot=%b busy=%b required 0000 0000 0 0", c, gnt_log[c], ack_log[c], plot_log[c], busy_log[c]);
      end
      n_vec++;
      if (x_log[c] !== 8'd0 || y_log[c] !== 7'd0 || c_log[c] !== 9'd0) begin
        n_bad++;
        $display("FAIL reset_vga c=%0d x=%0d y=%0d col=%h required 0 0 000", c, x_log[c], y_log[c], c_log[c]);
      end
    end
    reset = 1'b0;
    run(2);
    n_vec++;
    if (gnt_log[0] !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_release_idle gnt=%b required 0000", gnt_log[0]);
    end
    n_vec++;
    if (gnt_log[1] !== 4'b0001 || busy_log[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_grant gnt=%b busy=%b required 0001 1", gnt_log[1], busy_log[1]);
    end
  endtask

  task automatic test_single();
    int nack;
    do_reset();
    rem[2] = 21; seg[2] = 21; xbase[2] = 50; col[2] = 9'h007;
    run(25);
    nack = 0;
    for (int c = 0; c < 24; c++) begin
      logic [3:0] ea;
      ea = (c >= 1 && c <= 21) ? 4'b0100 : 4'b0000;
      if (ack_log[c][2]) nack++;
      n_vec++;
      if (ack_log[c] !== ea) begin
        n_bad++;
        $display("FAIL single_ack c=%0d ack=%b required %b", c, ack_log[c], ea);
      end
      if (c >= 2 && c <= 22) begin
        n_vec++;
        if (plot_log[c] !== 1'b1 || x_log[c] !== 8'(48 + c) || y_log[c] !== 7'd30 || c_log[c] !== 9'h007) begin
          n_bad++;
          $display("FAIL single_pixel c=%0d plot=%b x=%0d y=%0d col=%h required 1 %0d 30 007", c, plot_log[c], x_log[c], y_log[c], c_log[c], 48 + c);
        end
      end
    end
    n_vec++;
    if (nack != 21) begin
      n_bad++;
      $display("FAIL single_ack_count got=%0d required 21", nack);
    end
    n_vec++;
    if (busy_log[22] !== 1'b0 || plot_log[23] !== 1'b0 || x_log[23] !== 8'd70) begin
      n_bad++;
      $display("FAIL single_tail busy=%b plot=%b x=%0d required 0 0 70", busy_log[22], plot_log[23], x_log[23]);
    end
    rem[0] = 1; seg[0] = 1; rem[3] = 1; seg[3] = 1;
    run(2);
    n_vec++;
    if (gnt_log[1] !== 4'b1000) begin
      n_bad++;
      $display("FAIL single_ptr3 gnt=%b required 1000", gnt_log[1]);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rem[i] = 6; seg[i] = 3;
    end
    run(20);
    for (int c = 0; c < 20; c++) begin
      logic [3:0] eg;
      eg = ((c % 4) == 0) ? 4'b0000 : (4'b0001 << ((c / 4) % 4));
      n_vec++;
      if (gnt_log[c] !== eg || ack_log[c] !== eg) begin
        n_bad++;
        $display("FAIL rr_order c=%0d gnt=%b ack=%b required %b", c, gnt_log[c], ack_log[c], eg);
      end
    end
  endtask

  task automatic test_burst_cap();
    int n0;
    do_reset();
    rem[0] = 30; xbase[0] = 100;
    rem[1] = 2; seg[1] = 2;
    run(30);
    n0 = 0;
    for (int c = 0; c < 22; c++) if (ack_log[c][0]) n0++;
    n_vec++;
    if (n0 != 21 || ack_log[21] !== 4'b0001 || ack_log[22] !== 4'b0000) begin
      n_bad++;
      $display("FAIL cap_count acks=%0d ack21=%b ack22=%b required 21 0001 0000", n0, ack_log[21], ack_log[22]);
    end
    n_vec++;
    if (gnt_log[22] !== 4'b0000 || gnt_log[23] !== 4'b0010 || ack_log[24] !== 4'b0010) begin
      n_bad++;
      $display("FAIL cap_handoff gnt22=%b gnt23=%b ack24=%b required 0000 0010 0010", gnt_log[22], gnt_log[23], ack_log[24]);
    end
    n_vec++;
    if (gnt_log[25] !== 4'b0000 || gnt_log[26] !== 4'b0001) begin
      n_bad++;
      $display("FAIL cap_resume_grant gnt25=%b gnt26=%b required 0000 0001", gnt_log[25], gnt_log[26]);
    end
    n_vec++;
    if (plot_log[27] !== 1'b1 || x_log[27] !== 8'd121 || x_log[22] !== 8'd120) begin
      n_bad++;
      $display("FAIL cap_resume_pixel plot=%b x27=%0d x22=%0d required 1 121 120", plot_log[27], x_log[27], x_log[22]);
    end
  endtask

  task automatic test_early_drop();
    int np;
    do_reset();
    rem[3] = 5;
    run(10);
    np = 0;
    for (int c = 0; c < 10; c++) if (plot_log[c]) np++;
    n_vec++;
    if (np != 5) begin
      n_bad++;
      $display("FAIL drop_plot_pulses got=%0d required 5", np);
    end
    n_vec++;
    if (ack_log[5] !== 4'b1000 || ack_log[6] !== 4'b0000 || gnt_log[6] !== 4'b1000 || busy_log[7] !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_end ack5=%b ack6=%b gnt6=%b busy7=%b required 1000 0000 1000 0", ack_log[5], ack_log[6], gnt_log[6], busy_log[7]);
    end
    rem[0] = 1; seg[0] = 1; rem[3] = 1; seg[3] = 1;
    run(2);
    n_vec++;
    if (gnt_log[1] !== 4'b0001) begin
      n_bad++;
      $display("FAIL drop_ptr0 gnt=%b required 0001", gnt_log[1]);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    rem[2] = 1; seg[2] = 1;
    run(3);
    rem[1] = 21; seg[1] = 21; xbase[1] = 10;
    run(11);
    n_vec++;
    if (ack_log[10] !== 4'b0010 || pix[1] != 10) begin
      n_bad++;
      $display("FAIL mid_progress ack10=%b pix=%0d required 0010 10", ack_log[10], pix[1]);
    end
    reset = 1'b1;
    run(2);
    n_vec++;
    if (gnt_log[1] !== 4'b0000 || plot_log[1] !== 1'b0 || busy_log[1] !== 1'b0 || x_log[1] !== 8'd0 || ack_log[1] !== 4'b0000) begin
      n_bad++;
      $display("FAIL mid_reset gnt=%b plot=%b busy=%b x=%0d ack=%b required 0000 0 0 0 0000", gnt_log[1], plot_log[1], busy_log[1], x_log[1], ack_log[1]);
    end
    reset = 1'b0;
    pix[1] = 0; rem[1] = 21;
    rem[3] = 1; seg[3] = 1;
    run(3);
    n_vec++;
    if (gnt_log[0] !== 4'b0000 || gnt_log[1] !== 4'b0010 || x_log[2] !== 8'd10) begin
      n_bad++;
      $display("FAIL mid_restart gnt0=%b gnt1=%b x2=%0d required 0000 0010 10", gnt_log[0], gnt_log[1], x_log[2]);
    end
  endtask

  initial begin
    clear_towers();
    reset = 1'b1;
    drive();
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_burst_cap();
    test_early_drop();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
